// File: rtl/mips_multicycle_ctrl_if.sv
// Control/IR bundle between the multi-cycle control FSM and the MIPS datapath.
// The controller uses master: it samples the IR fields and flags, and drives the strobes.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute, waits on memory,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus,
  output logic [3:0]             o_state,
  output logic                   o_instr_done,
  output logic [CNT_WIDTH-1:0]   o_instr_count,
  output logic                   o_halted,
  output logic [1:0]             o_trap_cause
);

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_EXEC_I   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd15
  } state_t;

  localparam logic [7:0]           LIMIT      = 8'(WAIT_LIMIT);
  localparam bit                   TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_nextState;
  logic [7:0]           r_waitCnt;
  logic [CNT_WIDTH-1:0] r_instrCount;
  logic [1:0]           r_trapCause;
  logic [1:0]           w_nextCause;
  logic                 w_waiting;
  logic                 w_timeout;
  logic                 w_instrDone;
  logic                 w_rLegal;
  logic                 w_halted;

  logic       w_pcEn;
  logic [1:0] w_pcSrc;
  logic       w_iord;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_regWrite;
  logic       w_regDst;
  logic       w_memToReg;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [2:0] w_aluCtrl;

  // An access that completes in the limit cycle wins over the timeout
  assign w_timeout = TIMEOUT_EN && (r_waitCnt == LIMIT) && !bus.mem_ready;

  always_comb begin
    w_rLegal = 1'b0;
    case (bus.funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_rLegal = 1'b1;
      default:                                                w_rLegal = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCause = r_trapCause;
    w_waiting   = 1'b0;
    w_instrDone = 1'b0;
    w_halted    = 1'b0;
    w_pcEn      = 1'b0;
    w_pcSrc     = 2'b00;
    w_iord      = 1'b0;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_irWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_regDst    = 1'b0;
    w_memToReg  = 1'b0;
    w_aluSrcA   = 1'b0;
    w_aluSrcB   = 2'b00;
    w_aluCtrl   = 3'b010;

    case (r_state)
      ST_RESET: w_nextState = ST_FETCH;

      ST_FETCH: begin
        w_waiting = 1'b1;
        w_memRead = 1'b1;
        w_aluSrcB = 2'b01;
        if (bus.mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcEn      = 1'b1;
          w_nextState = ST_DECODE;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
          w_nextCause = 2'b10;
        end
      end

      ST_DECODE: begin
        w_aluSrcB = 2'b11;
        case (bus.opcode)
          6'b000000: begin
            if (w_rLegal) begin
              w_nextState = ST_EXEC_R;
            end else begin
              w_nextState = ST_TRAP;
              w_nextCause = 2'b01;
            end
          end
          6'b100011, 6'b101011: w_nextState = ST_MEM_ADDR;
          6'b001000:            w_nextState = ST_EXEC_I;
          6'b000100:            w_nextState = ST_BRANCH;
          6'b000010:            w_nextState = ST_JUMP;
          default: begin
            w_nextState = ST_TRAP;
            w_nextCause = 2'b01;
          end
        endcase
      end

      ST_MEM_ADDR: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_nextState = (bus.opcode == 6'b100011) ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD: begin
        w_waiting = 1'b1;
        w_memRead = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) begin
          w_nextState = ST_MEM_WB;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
          w_nextCause = 2'b10;
        end
      end

      ST_MEM_WB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_MEM_WR: begin
        w_waiting  = 1'b1;
        w_memWrite = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) begin
          w_instrDone = 1'b1;
          w_nextState = ST_FETCH;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
          w_nextCause = 2'b10;
        end
      end

      ST_EXEC_R: begin
        w_aluSrcA = 1'b1;
        case (bus.funct)
          6'b100010: w_aluCtrl = 3'b110;
          6'b100100: w_aluCtrl = 3'b000;
          6'b100101: w_aluCtrl = 3'b001;
          6'b101010: w_aluCtrl = 3'b111;
          default:   w_aluCtrl = 3'b010;
        endcase
        w_nextState = ST_R_WB;
      end

      ST_R_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_EXEC_I: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_nextState = ST_I_WB;
      end

      ST_I_WB: begin
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_BRANCH: begin
        w_aluSrcA   = 1'b1;
        w_aluCtrl   = 3'b110;
        w_pcSrc     = 2'b01;
        w_pcEn      = bus.zero;
        w_instrDone = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_JUMP: begin
        w_pcSrc     = 2'b10;
        w_pcEn      = 1'b1;
        w_instrDone = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_TRAP: w_halted = 1'b1;

      default: w_nextState = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_trapCause  <= 2'b00;
      r_instrCount <= '0;
    end else begin
      r_state     <= w_nextState;
      r_trapCause <= w_nextCause;
      if (w_instrDone) begin
        r_instrCount <= r_instrCount + CNT_ONE;
      end
    end
  end

  // Wait counter only measures consecutive stalled cycles within one waiting state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= 8'd0;
    end else if (w_nextState != r_state) begin
      r_waitCnt <= 8'd0;
    end else if (w_waiting && !bus.mem_ready) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  assign bus.pc_en      = w_pcEn;
  assign bus.pc_src     = w_pcSrc;
  assign bus.iord       = w_iord;
  assign bus.mem_read   = w_memRead;
  assign bus.mem_write  = w_memWrite;
  assign bus.ir_write   = w_irWrite;
  assign bus.reg_write  = w_regWrite;
  assign bus.reg_dst    = w_regDst;
  assign bus.mem_to_reg = w_memToReg;
  assign bus.alu_src_a  = w_aluSrcA;
  assign bus.alu_src_b  = w_aluSrcB;
  assign bus.alu_ctrl   = w_aluCtrl;

  assign o_state       = r_state;
  assign o_instr_done  = w_instrDone;
  assign o_instr_count = r_instrCount;
  assign o_halted      = w_halted;
  assign o_trap_cause  = r_trapCause;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is expanded into its expected
// state walk from the ISA rules, then driven cycle by cycle and compared.
module tb_mips_multicycle_ctrl;

  localparam int LIMIT = 4;

  localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_RD = 4,
                 S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC_R = 7, S_R_WB = 8, S_EXEC_I = 9,
                 S_I_WB = 10, S_BRANCH = 11, S_JUMP = 12, S_TRAP = 15;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  typedef struct packed {
    logic       pcEn;
    logic [1:0] pcSrc;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluCtrl;
    logic       halted;
  } strobes_t;

  typedef struct {
    int st;
    bit ready;
    int cause;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic        instrDone;
  logic [31:0] instrCount;
  logic        halted;
  logic [1:0]  trapCause;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] modelCount = '0;
  step_t       plan[$];
  logic [5:0]  rFuncts [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .CNT_WIDTH (32),
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_state      (state),
    .o_instr_done (instrDone),
    .o_instr_count(instrCount),
    .o_halted     (halted),
    .o_trap_cause (trapCause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic zeroIn, input logic ready);
    @(negedge clk);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = zeroIn;
    bus.mem_ready = ready;
    #1;
  endtask

  function automatic strobes_t getObs();
    strobes_t s;
    s.pcEn     = bus.pc_en;
    s.pcSrc    = bus.pc_src;
    s.iord     = bus.iord;
    s.memRead  = bus.mem_read;
    s.memWrite = bus.mem_write;
    s.irWrite  = bus.ir_write;
    s.regWrite = bus.reg_write;
    s.regDst   = bus.reg_dst;
    s.memToReg = bus.mem_to_reg;
    s.aluSrcA  = bus.alu_src_a;
    s.aluSrcB  = bus.alu_src_b;
    s.aluCtrl  = bus.alu_ctrl;
    s.halted   = halted;
    return s;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      foreach (rFuncts[k]) if (rFuncts[k] == fn) return K_R;
      return K_ILL;
    end
    case (op)
      6'd35:   return K_LW;
      6'd43:   return K_SW;
      6'd8:    return K_ADDI;
      6'd4:    return K_BEQ;
      6'd2:    return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] aluFor(input logic [5:0] fn);
    case (fn)
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Per-state strobe table; anything not listed is 0 and the ALU defaults to add
  function automatic strobes_t expStrobes(input int st, input bit ready,
                                          input logic zeroIn, input logic [5:0] fn);
    strobes_t s;
    s = '0;
    s.aluCtrl = 3'b010;
    case (st)
      S_FETCH: begin
        s.memRead = 1'b1; s.aluSrcB = 2'b01;
        if (ready) begin s.irWrite = 1'b1; s.pcEn = 1'b1; end
      end
      S_DECODE:   s.aluSrcB = 2'b11;
      S_MEM_ADDR: begin s.aluSrcA = 1'b1; s.aluSrcB = 2'b10; end
      S_MEM_RD:   begin s.memRead = 1'b1; s.iord = 1'b1; end
      S_MEM_WB:   begin s.regWrite = 1'b1; s.memToReg = 1'b1; end
      S_MEM_WR:   begin s.memWrite = 1'b1; s.iord = 1'b1; end
      S_EXEC_R:   begin s.aluSrcA = 1'b1; s.aluCtrl = aluFor(fn); end
      S_R_WB:     begin s.regWrite = 1'b1; s.regDst = 1'b1; end
      S_EXEC_I:   begin s.aluSrcA = 1'b1; s.aluSrcB = 2'b10; end
      S_I_WB:     s.regWrite = 1'b1;
      S_BRANCH:   begin s.aluSrcA = 1'b1; s.aluCtrl = 3'b110; s.pcSrc = 2'b01; s.pcEn = zeroIn; end
      S_JUMP:     begin s.pcSrc = 2'b10; s.pcEn = 1'b1; end
      S_TRAP:     s.halted = 1'b1;
      default:    ;
    endcase
    return s;
  endfunction

  task automatic addStep(input int st, input bit ready, input int cause);
    step_t s;
    s.st = st; s.ready = ready; s.cause = cause;
    plan.push_back(s);
  endtask

  task automatic addWait(input int st, input int waits, inout bit trapped);
    if (waits > LIMIT) begin
      for (int k = 0; k <= LIMIT; k++) addStep(st, 1'b0, 0);
      addStep(S_TRAP, 1'($urandom_range(0, 1)), 2);
      trapped = 1'b1;
    end else begin
      for (int k = 0; k < waits; k++) addStep(st, 1'b0, 0);
      addStep(st, 1'b1, 0);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".state"}, state, S_RESET);
    checkOutput({tag, ".strobes"}, getObs(), expStrobes(S_RESET, 1'b0, 1'b0, 6'd0));
    checkOutput({tag, ".done"}, instrDone, 1'b0);
    checkOutput({tag, ".count"}, instrCount, 32'd0);
    checkOutput({tag, ".cause"}, trapCause, 2'b00);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkReset("release");
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic zeroIn,
                          input int fw, input int mw, input int abortAt);
    int  kind;
    bit  trapped;
    bit  retire;
    int  last;
    int  cause;
    kind    = classify(op, fn);
    trapped = 1'b0;
    plan.delete();
    addWait(S_FETCH, fw, trapped);
    if (!trapped) begin
      addStep(S_DECODE, 1'($urandom_range(0, 1)), 0);
      case (kind)
        K_R:    begin addStep(S_EXEC_R, 1'($urandom_range(0, 1)), 0); addStep(S_R_WB, 1'($urandom_range(0, 1)), 0); end
        K_LW: begin
          addStep(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0);
          addWait(S_MEM_RD, mw, trapped);
          if (!trapped) addStep(S_MEM_WB, 1'($urandom_range(0, 1)), 0);
        end
        K_SW: begin
          addStep(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0);
          addWait(S_MEM_WR, mw, trapped);
        end
        K_ADDI: begin addStep(S_EXEC_I, 1'($urandom_range(0, 1)), 0); addStep(S_I_WB, 1'($urandom_range(0, 1)), 0); end
        K_BEQ:  addStep(S_BRANCH, 1'($urandom_range(0, 1)), 0);
        K_J:    addStep(S_JUMP, 1'($urandom_range(0, 1)), 0);
        default: begin addStep(S_TRAP, 1'($urandom_range(0, 1)), 1); trapped = 1'b1; end
      endcase
    end
    retire = !trapped;
    last   = plan.size() - 1;
    cause  = 0;
    for (int i = 0; i < plan.size(); i++) begin
      applyStimulus(op, fn, zeroIn, plan[i].ready);
      checkOutput($sformatf("op%0h.state@%0d", op, i), state, plan[i].st);
      checkOutput($sformatf("op%0h.strobes@%0d", op, i), getObs(),
                  expStrobes(plan[i].st, plan[i].ready, zeroIn, fn));
      checkOutput($sformatf("op%0h.done@%0d", op, i), instrDone, (retire && i == last));
      checkOutput($sformatf("op%0h.count@%0d", op, i), instrCount, modelCount);
      checkOutput($sformatf("op%0h.cause@%0d", op, i), trapCause, plan[i].cause);
      cause = plan[i].cause;
      if (i == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkReset("abort");
        modelCount = '0;
        return;
      end
    end
    if (retire) modelCount = modelCount + 32'd1;
    if (trapped) begin
      for (int c = 0; c < 20; c++) begin
        applyStimulus(6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checkOutput($sformatf("trap.state@%0d", c), state, S_TRAP);
        checkOutput($sformatf("trap.strobes@%0d", c), getObs(), expStrobes(S_TRAP, 1'b0, 1'b0, 6'd0));
        checkOutput($sformatf("trap.count@%0d", c), instrCount, modelCount);
        checkOutput($sformatf("trap.cause@%0d", c), trapCause, cause);
      end
    end
  endtask

  task automatic resetAgain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkReset("reset");
    modelCount = '0;
    releaseReset();
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         k;

    rst_n         = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checkReset("por");
    releaseReset();

    runInstr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    runInstr(6'b100011, 6'd0, 1'b0, 0, 3, -1);
    runInstr(6'b000100, 6'd0, 1'b1, 0, 0, -1);
    runInstr(6'b000100, 6'd0, 1'b0, 0, 0, -1);
    runInstr(6'b000000, 6'b101010, 1'b0, 4, 0, -1);
    runInstr(6'b101011, 6'd0, 1'b0, 1, 4, -1);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      fn = 6'($urandom);
      case (k)
        0:       begin op = 6'd0; fn = rFuncts[$urandom_range(0, 4)]; end
        1:       op = 6'd35;
        2:       op = 6'd43;
        3:       op = 6'd8;
        4:       op = 6'd4;
        default: op = 6'd2;
      endcase
      runInstr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, LIMIT), $urandom_range(0, LIMIT), -1);
    end

    runInstr(6'b111111, 6'd0, 1'b0, 0, 0, -1);
    resetAgain();
    runInstr(6'b001000, 6'd0, 1'b0, 0, 0, -1);
    runInstr(6'b000000, 6'b000000, 1'b0, 0, 0, -1);
    resetAgain();
    runInstr(6'b000010, 6'd0, 1'b0, LIMIT + 1, 0, -1);
    resetAgain();
    runInstr(6'b100011, 6'd0, 1'b0, 0, LIMIT + 1, -1);
    resetAgain();
    runInstr(6'b000000, 6'b100101, 1'b0, 0, 0, -1);
    runInstr(6'b101011, 6'd0, 1'b0, 0, 2, 4);
    releaseReset();
    runInstr(6'b000000, 6'b100100, 1'b0, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath: PC register, instruction/data memory, IR, register file and ALU.
- Decodes opcode/funct from the IR and drives Moore-style control strobes.
- Waits on a memory ready handshake and traps on illegal instructions or memory timeout.
- Sits beside the datapath in mips_processor and replaces the free-running pc + 4 update.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter.
- WAIT_LIMIT, 255, max cycles waiting for mem_ready before trap; 0 disables timeout. Wait counter is 8 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC mux select: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write register select: 1 rd, 0 rt.
- mem_to_reg  out  1  write data select: 1 MDR, 0 ALUOut.
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_ctrl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current state encoding.
- instr_done  out  1  one-cycle pulse on instruction retire.
- instr_count  out  CNT_WIDTH  retired-instruction count.
- halted  out  1  high in TRAP.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout.

Behaviour:
- State encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=15.
- Reset (rst low, asynchronous): state=RESET, instr_count=0, wait_cnt=0, trap_cause=00.
- RESET drives all strobes 0, alu_ctrl=010, and goes to FETCH on the next edge.
- Outputs are decoded from state only, except pc_en/ir_write in FETCH and pc_en in BRANCH. Signals not listed for a state are 0; alu_ctrl defaults to 010.
- FETCH: mem_read=1, iord=0, alu_src_b=01.
  - When mem_ready=1: ir_write=1, pc_en=1, pc_src=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_b=11 (branch target precompute). Next state by opcode:
  - 000000 with funct in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} -> EXEC_R.
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 001000 (addi) -> EXEC_I.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - Anything else -> TRAP with trap_cause=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct. Next R_WB.
- R_WB: reg_write=1, reg_dst=1. Next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. Next I_WB.
- I_WB: reg_write=1, reg_dst=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.
- TRAP: halted=1, all strobes 0. Sticky until reset; trap_cause holds its value.
- Cycle counts at zero wait states: R-type/addi/sw 4, lw 5, beq/j 3. Each extra cycle with mem_ready low adds one cycle.
- instr_done=1 during MEM_WB, R_WB, I_WB, BRANCH, JUMP, and MEM_WR when mem_ready=1. instr_count increments on that same edge and wraps modulo 2^CNT_WIDTH.
- Memory timeout:
  - wait_cnt increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0, and clears on any state change.
  - If WAIT_LIMIT!=0 and wait_cnt==WAIT_LIMIT with mem_ready still 0: next state TRAP, trap_cause=10.
  - mem_ready=1 in the limit cycle takes priority: the access completes, no trap.
- mem_ready is ignored in non-waiting states.
- rst asserted mid-instruction aborts immediately to RESET; no strobe may be high while rst is low.

Test Plan:
- Release reset, mem_ready=1 always, feed add (op 000000, funct 100000) -> states 0,1,2,7,8,1.
  - ir_write and pc_en high in cycle 1; alu_ctrl=010 in EXEC_R; reg_write=1, reg_dst=1 in R_WB.
  - instr_done pulses once; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, iord=1; then MEM_WB with mem_to_reg=1; 8 cycles total.
- beq with zero=1, then beq with zero=0 -> BRANCH shows pc_src=01, pc_en=1 then 0; each instruction 3 cycles; instr_count +2.
- opcode 111111 (and separately R-type funct 000000) -> DECODE then TRAP: halted=1, trap_cause=01, all strobes 0 for 20 cycles; instr_count unchanged.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> TRAP after 5 FETCH cycles with trap_cause=10. Repeat with mem_ready=1 in the 5th cycle -> DECODE, no trap.
- Assert rst low during MEM_WR with mem_write=1 -> mem_write drops asynchronously; state=0, instr_count=0. Release -> FETCH next cycle.
